agc_gain_ctrl: RTL and testbench

//  Amplitude-control loop stage directly downstream of the |x|^2 power stage (abs_square).

---
 rtl/agc_gain_ctrl_pkg.sv | 38 +++
 rtl/agc_power_avg.sv | 47 ++++
 rtl/agc_gain_ctrl.sv | 150 +++++++++++++++
 tb/tb_agc_gain_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/agc_gain_ctrl_pkg.sv
// Shared reset level, FSM/decision encodings, default loop window and the saturating gain step.
package agc_gain_ctrl_pkg;

   localparam logic RST_VAL = 1'b0;
   localparam int unsigned DEF_TARGET = 1024;
   localparam int unsigned DEF_HYST = 64;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_COMPARE = 2'd1,
      ST_UPDATE  = 2'd2
   } agc_state_e;

   typedef enum logic [1:0] {
      DEC_HOLD = 2'd0,
      DEC_UP   = 2'd1,
      DEC_DOWN = 2'd2
   } agc_dec_e;

   // Done in 9 bits so a step past 0 or 255 clamps instead of wrapping.
   function automatic logic [8:0] step_gain9(input logic [7:0] gain, input agc_dec_e dec,
                                             input logic [8:0] step, input logic [8:0] gmin,
                                             input logic [8:0] gmax);
      logic [8:0] g9;
      logic [8:0] sum;
      logic [8:0] res;
      g9  = {1'b0, gain};
      sum = g9 + step;
      res = g9;
      unique case (dec)
         DEC_UP:   res = (sum > gmax) ? gmax : sum;
         DEC_DOWN: res = (g9 < gmin + step) ? gmin : g9 - step;
         default:  res = g9;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/agc_power_avg.sv
// Block accumulator: sums 2^LOG2_N accepted power samples; done_o flags the edge taking the last one.
// avg_o is the running sum >> LOG2_N (valid as a mean once the block is complete); clr_i wins over valid_i.
module agc_power_avg
   import agc_gain_ctrl_pkg::*;
#(
   parameter int unsigned LOG2_N = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] power_i,
   input  logic        valid_i,
   input  logic        clr_i,
   output logic        done_o,
   output logic [15:0] avg_o
);

   localparam int unsigned AW = 16 + LOG2_N;

   logic [AW-1:0]     acc_q, acc_d;
   logic [LOG2_N-1:0] cnt_q, cnt_d;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (valid_i) begin
         acc_d = acc_q + AW'(power_i);
         cnt_d = cnt_q + LOG2_N'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_VAL) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign done_o = valid_i && !clr_i && (cnt_q == '1);
   assign avg_o  = acc_q[AW-1:LOG2_N];

endmodule

// File: rtl/agc_gain_ctrl.sv
// AGC loop stage: averages 2^LOG2_N power samples, steps the gain word; gain_o/gain_valid_o 2 edges after last sample.
// Samples offered while ready_o=0 (COMPARE/UPDATE) are dropped. Lock detector built only with AGC_LOCK_DET_EN.
module agc_gain_ctrl
   import agc_gain_ctrl_pkg::*;
#(
   parameter int unsigned LOG2_N    = 4,
   parameter int unsigned TARGET    = DEF_TARGET,
   parameter int unsigned HYST      = DEF_HYST,
   parameter int unsigned GAIN_INIT = 64,
   parameter int unsigned GAIN_STEP = 1,
   parameter int unsigned GAIN_MIN  = 0,
   parameter int unsigned GAIN_MAX  = 255,
   parameter int unsigned LOCK_CNT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] power_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [15:0] avg_o,
   output logic [7:0]  gain_o,
   output logic        gain_valid_o
`ifdef AGC_LOCK_DET_EN
   ,
   output logic        lock_o
`endif
);

   localparam logic [16:0] HI_TH      = 17'(TARGET + HYST);
   localparam logic [16:0] LO_TH      = 17'(TARGET - HYST);
   localparam logic [8:0]  STEP9      = 9'(GAIN_STEP);
   localparam logic [8:0]  MIN9       = 9'(GAIN_MIN);
   localparam logic [8:0]  MAX9       = 9'(GAIN_MAX);
   localparam logic [7:0]  GAIN_INIT8 = 8'(GAIN_INIT);

   agc_state_e  state_q, state_d;
   logic        ready_q, ready_d;
   logic [15:0] avg_q, avg_d;
   logic [7:0]  gain_q, gain_d;
   logic        gain_vld_q, gain_vld_d;

   logic        blk_done;
   logic [15:0] blk_avg;
   agc_dec_e    dec;
   logic [8:0]  gain9;
   logic        gain9_msb_unused;

   agc_power_avg #(.LOG2_N(LOG2_N)) u_power_avg (
      .clk     (clk),
      .rst     (rst),
      .power_i (power_i),
      .valid_i (valid_i && ready_q),
      .clr_i   (state_q == ST_UPDATE),
      .done_o  (blk_done),
      .avg_o   (blk_avg)
   );

   // Window bounds are inclusive: only strictly outside TARGET+-HYST steps the gain.
   always_comb begin
      dec = DEC_HOLD;
      if ({1'b0, avg_q} > HI_TH)
         dec = DEC_DOWN;
      else if ({1'b0, avg_q} < LO_TH)
         dec = DEC_UP;
   end

   assign gain9            = step_gain9(gain_q, dec, STEP9, MIN9, MAX9);
   assign gain9_msb_unused = gain9[8];

`ifdef AGC_LOCK_DET_EN
   localparam int unsigned LCW = $clog2(LOCK_CNT + 1);
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   logic           lock_q, lock_d;
`endif

   always_comb begin
      state_d    = state_q;
      ready_d    = ready_q;
      avg_d      = avg_q;
      gain_d     = gain_q;
      gain_vld_d = 1'b0;
`ifdef AGC_LOCK_DET_EN
      lock_cnt_d = lock_cnt_q;
      lock_d     = lock_q;
`endif
      unique case (state_q)
         ST_ACCUM: begin
            if (blk_done) begin
               state_d = ST_COMPARE;
               ready_d = 1'b0;
            end
         end
         ST_COMPARE: begin
            avg_d   = blk_avg;
            state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            gain_d     = gain9[7:0];
            gain_vld_d = 1'b1;
            state_d    = ST_ACCUM;
            ready_d    = 1'b1;
`ifdef AGC_LOCK_DET_EN
            // A clamped step is still an out-of-window decision and clears the count.
            if (dec != DEC_HOLD)
               lock_cnt_d = '0;
            else if (lock_cnt_q != LCW'(LOCK_CNT))
               lock_cnt_d = lock_cnt_q + LCW'(1);
            lock_d = (lock_cnt_d == LCW'(LOCK_CNT));
`endif
         end
         default: begin
            state_d = ST_ACCUM;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_VAL) begin
         state_q    <= ST_ACCUM;
         ready_q    <= 1'b1;
         avg_q      <= '0;
         gain_q     <= GAIN_INIT8;
         gain_vld_q <= 1'b0;
`ifdef AGC_LOCK_DET_EN
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         avg_q      <= avg_d;
         gain_q     <= gain_d;
         gain_vld_q <= gain_vld_d;
`ifdef AGC_LOCK_DET_EN
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= lock_d;
`endif
      end
   end

   assign ready_o      = ready_q;
   assign avg_o        = avg_q;
   assign gain_o       = gain_q;
   assign gain_valid_o = gain_vld_q;
`ifdef AGC_LOCK_DET_EN
   assign lock_o       = lock_q;
`endif

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed bench for agc_gain_ctrl: vector table of constant blocks plus gap, reset, saturation and lock sequences.
module tb_agc_gain_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] power_i = '0;
   logic        valid_i = 1'b0;

   logic        ready, gv;
   logic [15:0] avg;
   logic [7:0]  gain;
   logic        hi_ready_unused, hi_gv_unused, lo_ready_unused, lo_gv_unused;
   logic [15:0] hi_avg, lo_avg;
   logic [7:0]  hi_gain, lo_gain;
`ifdef AGC_LOCK_DET_EN
   logic        lock, hi_lock_unused, lo_lock_unused;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   agc_gain_ctrl dut (
      .clk(clk), .rst(rst), .power_i(power_i), .valid_i(valid_i),
      .ready_o(ready), .avg_o(avg), .gain_o(gain), .gain_valid_o(gv)
`ifdef AGC_LOCK_DET_EN
      , .lock_o(lock)
`endif
   );

   agc_gain_ctrl #(.GAIN_INIT(254)) dut_hi (
      .clk(clk), .rst(rst), .power_i(power_i), .valid_i(valid_i),
      .ready_o(hi_ready_unused), .avg_o(hi_avg), .gain_o(hi_gain), .gain_valid_o(hi_gv_unused)
`ifdef AGC_LOCK_DET_EN
      , .lock_o(hi_lock_unused)
`endif
   );

   agc_gain_ctrl #(.GAIN_INIT(1)) dut_lo (
      .clk(clk), .rst(rst), .power_i(power_i), .valid_i(valid_i),
      .ready_o(lo_ready_unused), .avg_o(lo_avg), .gain_o(lo_gain), .gain_valid_o(lo_gv_unused)
`ifdef AGC_LOCK_DET_EN
      , .lock_o(lo_lock_unused)
`endif
   );

   typedef struct {
      logic [15:0] p;
      logic [15:0] e_avg;
      logic [7:0]  e_gain;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      valid_i = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Offers samples until n have been accepted; returns just after the accepting edge.
   task automatic feed(input logic [15:0] p, input int n, input bit gappy);
      int  acc_n = 0;
      int  cyc   = 0;
      bit  ph    = 1'b1;
      bit  take;
      while (acc_n < n && cyc < 200) begin
         @(negedge clk);
         power_i = p;
         valid_i = gappy ? ph : 1'b1;
         ph      = !ph;
         take    = valid_i && ready;
         @(posedge clk);
         if (take) acc_n++;
         cyc++;
      end
      chk("feed_accept_count", acc_n, n);
   endtask

   task automatic check_decision(input string nm, input logic [15:0] e_avg,
                                 input logic [7:0] e_gain, input bit junk);
      @(negedge clk);
      valid_i = junk;
      power_i = 16'hFFFF;
      chk({nm, "_ready_lo"}, ready, 0);
      chk({nm, "_gv_k"}, gv, 0);
      @(negedge clk);
      chk({nm, "_avg"}, avg, e_avg);
      chk({nm, "_gv_k1"}, gv, 0);
      @(negedge clk);
      valid_i = 1'b0;
      chk({nm, "_gv_k2"}, gv, 1);
      chk({nm, "_gain"}, gain, e_gain);
      chk({nm, "_ready_hi"}, ready, 1);
      @(negedge clk);
      chk({nm, "_gv_k3"}, gv, 0);
   endtask

   initial begin
      int pulses;
      vecs[0] = '{16'd2000,  16'd2000,  8'd63};
      vecs[1] = '{16'd1024,  16'd1024,  8'd63};
      vecs[2] = '{16'd1088,  16'd1088,  8'd63};
      vecs[3] = '{16'd960,   16'd960,   8'd63};
      vecs[4] = '{16'd1089,  16'd1089,  8'd62};
      vecs[5] = '{16'd959,   16'd959,   8'd63};
      vecs[6] = '{16'd281,   16'd281,   8'd64};
      vecs[7] = '{16'd0,     16'd0,     8'd65};
      vecs[8] = '{16'd65535, 16'd65535, 8'd64};

      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_avg", avg, 0);
      chk("rst_gain", gain, 64);
      chk("rst_gv", gv, 0);
      chk("rst_hi_gain", hi_gain, 254);
      chk("rst_lo_gain", lo_gain, 1);
`ifdef AGC_LOCK_DET_EN
      chk("rst_lock", lock, 0);
`endif

      for (int i = 0; i < 9; i++) begin
         feed(vecs[i].p, 16, 1'b0);
         check_decision($sformatf("vec%0d", i), vecs[i].e_avg, vecs[i].e_gain, 1'b0);
      end

      // Alternating valid; samples offered during COMPARE/UPDATE must be dropped.
      apply_reset();
      feed(16'd700, 16, 1'b1);
      check_decision("gappy", 16'd700, 8'd65, 1'b1);
      feed(16'd1024, 16, 1'b0);
      check_decision("after_drop", 16'd1024, 8'd65, 1'b0);

      // Reset half-way through a block.
      feed(16'd3000, 8, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      chk("midrst_gv_during", gv, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_avg", avg, 0);
      chk("midrst_gain", gain, 64);
      chk("midrst_ready", ready, 1);
      feed(16'd1024, 8, 1'b0);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         valid_i = 1'b0;
         if (gv) pulses++;
      end
      chk("midrst_no_early_pulse", pulses, 0);
      feed(16'd1024, 8, 1'b0);
      check_decision("midrst_fresh", 16'd1024, 8'd64, 1'b0);

      // |16 - 5j|^2 = 281 from the power stage.
      apply_reset();
      feed(16'd281, 16, 1'b0);
      check_decision("abs_sq", 16'd281, 8'd65, 1'b0);

      // Saturation at both ends.
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         feed(16'd0, 16, 1'b0);
         check_decision($sformatf("zero%0d", i), 16'd0, 8'(65 + i), 1'b0);
         chk($sformatf("sat_hi_gain%0d", i), hi_gain, 255);
         chk($sformatf("sat_hi_avg%0d", i), hi_avg, 0);
      end
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         feed(16'hFFFF, 16, 1'b0);
         check_decision($sformatf("full%0d", i), 16'hFFFF, 8'(63 - i), 1'b0);
         chk($sformatf("sat_lo_gain%0d", i), lo_gain, 0);
         chk($sformatf("sat_lo_avg%0d", i), lo_avg, 65535);
      end

`ifdef AGC_LOCK_DET_EN
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         feed(16'd1024, 16, 1'b0);
         check_decision($sformatf("lockblk%0d", i), 16'd1024, 8'd64, 1'b0);
         chk($sformatf("lock_after%0d", i), lock, (i == 3) ? 1 : 0);
      end
      feed(16'd2000, 16, 1'b0);
      check_decision("unlock", 16'd2000, 8'd63, 1'b0);
      chk("lock_cleared", lock, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
